// File: rtl/btb_pkg.sv
// Shared types for the set-associative BTB: branch-type encoding, flush FSM
// state encoding and the PC tag fold.
package btb_pkg;

  typedef enum logic [1:0] {
    BR_DIRECT   = 2'b00,
    BR_CALL     = 2'b01,
    BR_RETURN   = 2'b10,
    BR_INDIRECT = 2'b11
  } br_type_e;

  localparam logic [0:0] FL_IDLE  = 1'b0;
  localparam logic [0:0] FL_CLEAR = 1'b1;

  // XOR successive w-bit chunks of v together; the result sits in bits [w-1:0].
  function automatic logic [31:0] fold_tag(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [31:0] mask;
    r    = '0;
    mask = (32'h1 << w) - 32'h1;
    for (int c = 0; c < 32; c++) begin
      if (c * w < 32) r = r ^ ((v >> (c * w)) & mask);
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU state for one BTB set: WAYS-1 tree bits, heap-indexed from 1.
// A tree bit of 1 means the victim lies in the upper-numbered half of that node.
module btb_plru #(
  parameter int WAYS = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clr,
  input  logic                    touch,
  input  logic [$clog2(WAYS)-1:0] way,
  output logic [$clog2(WAYS)-1:0] victim
);
  localparam int LW = $clog2(WAYS);

  logic [WAYS-1:1] tree;
  logic [WAYS-1:1] tree_nxt;

  // Leaf heap index is WAYS+way; node k on its path points away from the touched side.
  always_comb begin
    int leaf;
    tree_nxt = tree;
    leaf     = WAYS + int'(way);
    for (int k = 1; k < WAYS; k++) begin
      for (int lv = 0; lv < LW; lv++) begin
        if ((leaf >> (LW - lv)) == k) tree_nxt[k] = (((leaf >> (LW - lv - 1)) & 1) == 0);
      end
    end
  end

  always_comb begin
    logic ok;
    int   leafw;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      ok    = 1'b1;
      leafw = WAYS + w;
      for (int k = 1; k < WAYS; k++) begin
        for (int lv = 0; lv < LW; lv++) begin
          if (((leafw >> (LW - lv)) == k) &&
              (tree[k] != (((leafw >> (LW - lv - 1)) & 1) != 0))) ok = 1'b0;
        end
      end
      if (ok) victim = LW'(w);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    tree <= '0;
    else if (clr)   tree <= '0;
    else if (touch) tree <= tree_nxt;
  end

endmodule

// File: rtl/branch_target_buffer_sa.sv
// N-way set-associative branch target buffer with tree-PLRU replacement and a
// runtime flush sequencer. Define BTB_PERF_CNT_EN to build the lookup/hit counters.
module branch_target_buffer_sa
  import btb_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 10
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             lookup_pc,
  output logic                    lookup_hit,
  output logic [$clog2(WAYS)-1:0] lookup_way,
  output logic [31:0]             lookup_bta,
  output logic [1:0]              lookup_type,
  input  logic                    touch_en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [31:0]             upd_pc,
  input  logic [31:0]             upd_bta,
  input  logic [1:0]              upd_type,
  input  logic                    flush,
  output logic                    flush_busy,
  output logic [31:0]             perf_lookups,
  output logic [31:0]             perf_hits
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WW    = $clog2(WAYS);

  typedef struct packed {
    logic [0:0]       state;
    logic [IDX_W-1:0] cnt;
  } flush_fsm_t;

  flush_fsm_t fl;

  logic [WAYS-1:0]  valid    [SETS];
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [31:0]      bta_mem  [SETS][WAYS];
  br_type_e         type_mem [SETS][WAYS];
  logic [WW-1:0]    victim   [SETS];

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic [WAYS-1:0]  lk_match, u_match;
  logic [WW-1:0]    lk_way, u_way, u_hit_way, u_free_way;
  logic             upd_fire;
  logic             unused_upd_lsbs;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = TAG_W'(fold_tag(lookup_pc >> (IDX_W + 2), TAG_W));
  assign u_idx  = upd_pc[IDX_W+1:2];
  assign u_tag  = TAG_W'(fold_tag(upd_pc >> (IDX_W + 2), TAG_W));
  assign unused_upd_lsbs = ^upd_pc[1:0];

  assign flush_busy = (fl.state == FL_CLEAR);

  // Update handshake: a request transfers on a cycle with upd_valid & upd_ready;
  // the requester holds upd_valid and the payload stable until that cycle.
  assign upd_ready = !flush_busy;
  assign upd_fire  = upd_valid && upd_ready;

  always_comb begin
    lk_match = '0;
    lk_way   = '0;
    for (int w = 0; w < WAYS; w++)
      lk_match[w] = valid[lk_idx][w] && (tag_mem[lk_idx][w] == lk_tag);
    for (int w = WAYS - 1; w >= 0; w--)
      if (lk_match[w]) lk_way = WW'(w);
  end

  assign lookup_hit  = (|lk_match) && !flush_busy;
  assign lookup_way  = lookup_hit ? lk_way : '0;
  assign lookup_bta  = lookup_hit ? bta_mem[lk_idx][lk_way] : lookup_pc + 32'd4;
  assign lookup_type = lookup_hit ? type_mem[lk_idx][lk_way] : BR_DIRECT;

  // Way choice: same-tag merge keeps the one-copy-per-tag invariant, then fill, then evict.
  always_comb begin
    u_match    = '0;
    u_hit_way  = '0;
    u_free_way = '0;
    for (int w = 0; w < WAYS; w++)
      u_match[w] = valid[u_idx][w] && (tag_mem[u_idx][w] == u_tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (u_match[w])       u_hit_way  = WW'(w);
      if (!valid[u_idx][w]) u_free_way = WW'(w);
    end
    if (|u_match)                u_way = u_hit_way;
    else if (!(&valid[u_idx]))   u_way = u_free_way;
    else                         u_way = victim[u_idx];
  end

  always_ff @(posedge clk) begin
    if (upd_fire) begin
      tag_mem[u_idx][u_way]  <= u_tag;
      bta_mem[u_idx][u_way]  <= upd_bta;
      type_mem[u_idx][u_way] <= br_type_e'(upd_type);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (fl.state == FL_CLEAR) begin
      valid[fl.cnt] <= '0;
    end else if (upd_fire) begin
      valid[u_idx][u_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fl.state <= FL_IDLE;
      fl.cnt   <= '0;
    end else if (flush) begin
      fl.state <= FL_CLEAR;
      fl.cnt   <= '0;
    end else if (fl.state == FL_CLEAR) begin
      if (fl.cnt == IDX_W'(SETS - 1)) begin
        fl.state <= FL_IDLE;
        fl.cnt   <= '0;
      end else begin
        fl.cnt <= fl.cnt + 1'b1;
      end
    end
  end

  // An update to a set overrides a same-cycle touch of that set.
  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic          upd_here;
    logic          touch_s;
    logic          clr_s;
    logic [WW-1:0] way_s;

    assign upd_here = upd_fire && (u_idx == IDX_W'(s));
    assign touch_s  = upd_here || (touch_en && lookup_hit && (lk_idx == IDX_W'(s)));
    assign way_s    = upd_here ? u_way : lk_way;
    assign clr_s    = (fl.state == FL_CLEAR) && (fl.cnt == IDX_W'(s));

    btb_plru #(.WAYS(WAYS)) u_plru (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr_s),
      .touch  (touch_s),
      .way    (way_s),
      .victim (victim[s])
    );
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] cnt_lookups;
  logic [31:0] cnt_hits;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_lookups <= '0;
      cnt_hits    <= '0;
    end else if (flush) begin
      cnt_lookups <= '0;
      cnt_hits    <= '0;
    end else begin
      if (!flush_busy && (cnt_lookups != '1)) cnt_lookups <= cnt_lookups + 32'd1;
      if (lookup_hit && (cnt_hits != '1))     cnt_hits    <= cnt_hits + 32'd1;
    end
  end

  assign perf_lookups = cnt_lookups;
  assign perf_hits    = cnt_hits;
`else
  assign perf_lookups = '0;
  assign perf_hits    = '0;
`endif

endmodule
